systolic_array_nxn_ctrl: RTL and testbench

Parametrised N x N output-stationary signed-integer systolic matrix multiplier with its own sequencing controller. It computes C = A x B for an N x K by K x N problem, where K is set at runtime. It accepts one A-column and one B-row per handshake, skews the lanes internally, flushes the array, then drains C one row per handshake. It is the drop-in compute tile for the GPU matmul path and replaces hand-skewed fixed-4x4 feeding.

---
 rtl/systolic_array_nxn_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_systolic_array_nxn_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn_ctrl.sv
`default_nettype none
// ============================================================================
// systolic_array_nxn_ctrl : N x N output-stationary signed systolic matmul
// with operand skew, flush and row-by-row drain sequencing.   Rev 1.0
// ============================================================================
module systolic_array_nxn_ctrl #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_W-1:0]    a_vec,
  input  logic [N*DATA_W-1:0]    b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row_idx,
  output logic [N*ACC_W-1:0]     c_row
);

  localparam int ROW_W = $clog2(N);
  localparam int FL_W  = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [KLEN_W-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              xfer, clr, run;

  // Skew chains: lane i taps stage i, so lane 0 feeds the array directly.
  logic signed [DATA_W-1:0] a_sk_q [N][N-1];
  logic signed [DATA_W-1:0] a_sk_d [N][N-1];
  logic signed [DATA_W-1:0] b_sk_q [N][N-1];
  logic signed [DATA_W-1:0] b_sk_d [N][N-1];
  logic signed [DATA_W-1:0] a_tap  [N][N];
  logic signed [DATA_W-1:0] b_tap  [N][N];

  logic signed [DATA_W-1:0] a_q   [N][N-1];
  logic signed [DATA_W-1:0] a_d   [N][N-1];
  logic signed [DATA_W-1:0] b_q   [N-1][N];
  logic signed [DATA_W-1:0] b_d   [N-1][N];
  logic signed [DATA_W-1:0] a_pe  [N][N];
  logic signed [DATA_W-1:0] b_pe  [N][N];
  logic signed [ACC_W-1:0]  acc_q [N][N];
  logic signed [ACC_W-1:0]  acc_d [N][N];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    row_d     = row_q;
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    run       = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          k_d     = k_len;
          cnt_d   = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        run      = 1'b1;
        in_ready = (cnt_q < k_q);
        xfer     = in_valid && in_ready;
        if (xfer) begin
          cnt_d = cnt_q + KLEN_W'(1);
          if ((cnt_q + KLEN_W'(1)) == k_q) begin
            state_d = S_FLUSH;
            flush_d = '0;
          end
        end
      end
      S_FLUSH: begin
        busy    = 1'b1;
        run     = 1'b1;
        flush_d = flush_q + FL_W'(1);
        // 2N-1 zero cycles let the last operand reach PE(N-1,N-1).
        if (flush_q == FL_W'(2 * N - 2)) begin
          state_d = S_DRAIN;
          row_d   = '0;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == ROW_W'(N - 1)) begin
            state_d = S_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_tap[i][0] = xfer ? a_vec[i*DATA_W +: DATA_W] : '0;
      b_tap[i][0] = xfer ? b_vec[i*DATA_W +: DATA_W] : '0;
      for (int s = 1; s < N; s++) begin
        a_tap[i][s] = a_sk_q[i][s-1];
        b_tap[i][s] = b_sk_q[i][s-1];
      end
      for (int s = 0; s < N - 1; s++) begin
        a_sk_d[i][s] = clr ? '0 : (run ? a_tap[i][s] : a_sk_q[i][s]);
        b_sk_d[i][s] = clr ? '0 : (run ? b_tap[i][s] : b_sk_q[i][s]);
      end
    end
    for (int i = 0; i < N; i++) begin
      a_pe[i][0] = a_tap[i][i];
      b_pe[0][i] = b_tap[i][i];
      for (int j = 1; j < N; j++) begin
        a_pe[i][j] = a_q[i][j-1];
        b_pe[j][i] = b_q[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1; j++) begin
        a_d[i][j] = clr ? '0 : (run ? a_pe[i][j] : a_q[i][j]);
        b_d[j][i] = clr ? '0 : (run ? b_pe[j][i] : b_q[j][i]);
      end
      for (int j = 0; j < N; j++) begin
        acc_d[i][j] = clr ? '0 :
                      (run ? acc_q[i][j] + ACC_W'(a_pe[i][j] * b_pe[i][j]) : acc_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      row_q   <= '0;
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N - 1; s++) begin
          a_sk_q[i][s] <= '0;
          b_sk_q[i][s] <= '0;
          a_q[i][s]    <= '0;
          b_q[s][i]    <= '0;
        end
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      a_sk_q  <= a_sk_d;
      b_sk_q  <= b_sk_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    c_row       = '0;
    out_row_idx = '0;
    if (state_q == S_DRAIN) begin
      out_row_idx = row_q;
      for (int j = 0; j < N; j++) begin
        c_row[j*ACC_W +: ACC_W] = acc_q[row_q][j];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_nxn_ctrl.sv
`default_nettype none
// Bench for systolic_array_nxn_ctrl: table vectors, hand-built corner sequences
// and random jobs, all checked against a plain matrix-product model.
module tb_systolic_array_nxn_ctrl;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KW   = 8;
  localparam int MAXK = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic [N*DW-1:0] a_vec = '0;
  logic [N*DW-1:0] b_vec = '0;
  logic            busy, done, in_ready, out_valid;
  logic [1:0]      out_row_idx;
  logic [N*AW-1:0] c_row;

  int  n_tests = 0;
  int  n_fail  = 0;
  byte a_m [N][MAXK];
  byte b_m [MAXK][N];
  int  c_m [N][N];

  typedef struct {
    int k; int a_val; int b_val; int vmode; int rmode;
    int stall_row; int stall_n; int exp_c; bit poke; bit lat;
  } vec_t;
  vec_t tbl [5];

  systolic_array_nxn_ctrl #(.N(N), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx), .c_row(c_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int k);
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += int'(a_m[i][kk]) * int'(b_m[kk][j]);
        c_m[i][j] = s;
      end
    end
  endfunction

  function automatic logic [N*DW-1:0] pack_a(input int kk);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = a_m[i][kk];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int kk);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = b_m[kk][j];
    return v;
  endfunction

  task automatic fill_uniform(input int av, input int bv);
    for (int kk = 0; kk < MAXK; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = byte'(av);
        b_m[kk][i] = byte'(bv);
      end
  endtask

  task automatic fill_random();
    for (int kk = 0; kk < MAXK; kk++)
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = byte'($urandom);
        b_m[kk][i] = byte'($urandom);
      end
  endtask

  // vmode: 0 always valid, 1 toggles 1-0-1-0, 2 random. rmode: 0 always ready, 1 random.
  task automatic run_job(input string tag, input int k, input int vmode, input int rmode,
                         input int stall_row, input int stall_n, input bit use_exp,
                         input int exp_c, input bit poke, input bit lat);
    int fed, rows, cyc, dones, done_cyc, stall_left, exp_lat;
    bit want, poked1, poked2;
    model(k);
    fed = 0; rows = 0; cyc = 1; dones = 0; done_cyc = -1;
    stall_left = stall_n; poked1 = 1'b0; poked2 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
    while (cyc < 600 && (dones == 0 || cyc <= done_cyc + 2)) begin
      chk({tag, "_in_ready"}, in_ready, fed < k);
      chk({tag, "_busy"}, busy, (dones == 0) && !done);
      start = 1'b0;
      if (poke && !poked1 && k > 0 && fed == k && !out_valid) begin
        start = 1'b1; k_len = KW'(k + 3); poked1 = 1'b1;
      end else if (poke && !poked2 && out_valid && rows == 1) begin
        start = 1'b1; k_len = KW'(k + 5); poked2 = 1'b1;
      end
      want = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 2) != 0);
      if (fed < k) begin
        in_valid = want;
        a_vec = want ? pack_a(fed) : N*DW'($urandom);
        b_vec = want ? pack_b(fed) : N*DW'($urandom);
        if (want && in_ready) fed++;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        a_vec = N*DW'($urandom);
        b_vec = N*DW'($urandom);
      end
      if (out_valid) begin
        if (rows < N) begin
          chk($sformatf("%s_row_idx", tag), out_row_idx, rows);
          for (int j = 0; j < N; j++) begin
            chk($sformatf("%s_c%0d%0d", tag, rows, j), $signed(c_row[j*AW +: AW]), c_m[rows][j]);
            if (use_exp)
              chk($sformatf("%s_tbl_c%0d%0d", tag, rows, j), $signed(c_row[j*AW +: AW]), exp_c);
          end
        end else begin
          chk({tag, "_extra_row"}, out_valid, 0);
        end
        if (rows == stall_row && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (out_ready) rows++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        dones++;
        if (dones == 1) done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_rows"}, rows, N);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_out_valid_end"}, out_valid, 0);
    if (lat) begin
      exp_lat = (k == 0) ? N + 1 : k + (2 * N - 1) + N + 1;
      chk({tag, "_latency"}, done_cyc, exp_lat);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_row_idx"}, out_row_idx, 0);
    chk({tag, "_c_row_nonzero"}, c_row != '0, 0);
  endtask

  initial begin
    tbl[0] = '{4,    2,    3, 1, 0,  2, 3,     24, 1'b0, 1'b0};
    tbl[1] = '{4, -128, -128, 0, 0, -1, 0,  65536, 1'b0, 1'b1};
    tbl[2] = '{4,  127, -128, 0, 0, -1, 0, -65024, 1'b0, 1'b1};
    tbl[3] = '{0,    5,    7, 0, 0, -1, 0,      0, 1'b0, 1'b1};
    tbl[4] = '{4,    3,   -5, 0, 0, -1, 0,    -60, 1'b1, 1'b0};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < MAXK; kk++) begin
        a_m[i][kk] = (i == kk) ? 8'sd1 : 8'sd0;
        b_m[kk][i] = byte'(kk * 4 + i);
      end
    run_job("ident", 4, 0, 0, -1, 0, 1'b0, 0, 1'b0, 1'b1);

    for (int t = 0; t < 5; t++) begin
      fill_uniform(tbl[t].a_val, tbl[t].b_val);
      run_job($sformatf("tbl%0d", t), tbl[t].k, tbl[t].vmode, tbl[t].rmode, tbl[t].stall_row,
              tbl[t].stall_n, 1'b1, tbl[t].exp_c, tbl[t].poke, tbl[t].lat);
    end

    fill_random();
    @(negedge clk);
    start = 1'b1; k_len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_vec = pack_a(0); b_vec = pack_b(0);
    @(negedge clk);
    a_vec = pack_a(1); b_vec = pack_b(1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midload_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready", in_ready, 0);
    run_job("after_rst", 4, 0, 0, -1, 0, 1'b0, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_job($sformatf("rnd%0d", r), $urandom_range(1, 20), 2, 1, -1, 0, 1'b0, 0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
